// File: rtl/bin_maxpool2x2.sv
// Binary 2x2 stride-2 max-pool: streams packed rows from the convolution output SRAM,
// ORs each 2x2 window and writes packed pooled rows, one word every two cycles.
//
// state | meaning
// IDLE  | waiting for pool_run; read/write addresses parked at 0
// READ  | issuing one row address per cycle across all images
// DRAIN | last address issued, waiting for the final pooled write
// FLUSH | degenerate run (no pairs or no images): one busy cycle, no traffic
module bin_maxpool2x2 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              pool_run,
    input  logic [4:0]        cfg_width,
    input  logic [7:0]        cfg_count,
    output logic              pool_busy,
    output logic [ADDR_W-1:0] pool_sram_read_address,
    input  logic [DATA_W-1:0] sram_pool_read_data,
    output logic [ADDR_W-1:0] pool_sram_write_address,
    output logic [DATA_W-1:0] pool_sram_write_data,
    output logic              pool_sram_write_enable
);

    localparam int WMAX = (DATA_W > 31) ? 31 : DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t              state;
    logic [4:0]          width_eff;
    logic [4:0]          pairs;
    logic [ADDR_W-1:0]   last_row;
    logic [7:0]          count_m1;
    logic [ADDR_W-1:0]   row_cnt;
    logic [7:0]          img_cnt;
    logic [ADDR_W-1:0]   base;
    logic                rd_vld;
    logic                rd_is_b;
    logic                rd_last;
    logic                wr_last;
    logic [DATA_W-1:0]   a_hold;

    logic [4:0]          width_in;
    logic [4:0]          pairs_in;
    logic                degenerate;
    logic                last_addr;
    logic [ADDR_W-1:0]   base_next;
    logic [DATA_W-1:0]   or_ab;
    logic [DATA_W-1:0]   pooled;

    always_comb begin
        width_in   = (cfg_width > 5'(WMAX)) ? 5'(WMAX) : cfg_width;
        pairs_in   = width_in >> 1;
        degenerate = (pairs_in == 5'd0) || (cfg_count == 8'd0);
        last_addr  = (row_cnt == last_row) && (img_cnt == count_m1);
        base_next  = base + ADDR_W'(width_eff);
    end

    // Column pairs beyond the configured width are forced to zero.
    always_comb begin
        or_ab  = a_hold | sram_pool_read_data;
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (j < int'(pairs)) begin
                pooled[j] = or_ab[2*j] | or_ab[2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                   <= IDLE;
            pool_busy               <= 1'b0;
            pool_sram_read_address  <= '0;
            pool_sram_write_address <= '0;
            pool_sram_write_data    <= '0;
            pool_sram_write_enable  <= 1'b0;
            width_eff               <= '0;
            pairs                   <= '0;
            last_row                <= '0;
            count_m1                <= '0;
            row_cnt                 <= '0;
            img_cnt                 <= '0;
            base                    <= '0;
            rd_vld                  <= 1'b0;
            rd_is_b                 <= 1'b0;
            rd_last                 <= 1'b0;
            wr_last                 <= 1'b0;
            a_hold                  <= '0;
        end else begin
            rd_vld                 <= (state == READ);
            rd_is_b                <= row_cnt[0];
            rd_last                <= (state == READ) && last_addr;
            pool_sram_write_enable <= 1'b0;

            if (rd_vld && !rd_is_b) begin
                a_hold <= sram_pool_read_data;
            end
            if (rd_vld && rd_is_b) begin
                pool_sram_write_data   <= pooled;
                pool_sram_write_enable <= 1'b1;
                wr_last                <= rd_last;
            end
            if (pool_sram_write_enable) begin
                pool_sram_write_address <= pool_sram_write_address + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pool_run) begin
                        pool_busy               <= 1'b1;
                        width_eff               <= width_in;
                        pairs                   <= pairs_in;
                        last_row                <= ADDR_W'({pairs_in, 1'b0}) - ADDR_W'(1);
                        count_m1                <= cfg_count - 8'd1;
                        row_cnt                 <= '0;
                        img_cnt                 <= '0;
                        base                    <= '0;
                        pool_sram_read_address  <= '0;
                        pool_sram_write_address <= '0;
                        state                   <= degenerate ? FLUSH : READ;
                    end
                end
                READ: begin
                    if (row_cnt == last_row) begin
                        if (img_cnt == count_m1) begin
                            state <= DRAIN;
                        end else begin
                            row_cnt                <= '0;
                            img_cnt                <= img_cnt + 8'd1;
                            base                   <= base_next;
                            pool_sram_read_address <= base_next;
                        end
                    end else begin
                        row_cnt                <= row_cnt + ADDR_W'(1);
                        pool_sram_read_address <= pool_sram_read_address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The final write is in flight this cycle; park both addresses.
                    if (pool_sram_write_enable && wr_last) begin
                        state                   <= IDLE;
                        pool_busy               <= 1'b0;
                        pool_sram_read_address  <= '0;
                        pool_sram_write_address <= '0;
                    end
                end
                FLUSH: begin
                    state     <= IDLE;
                    pool_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_maxpool2x2.sv
// Directed bench for bin_maxpool2x2: SRAM model, write/read logger and cycle-exact checks.
module tb_bin_maxpool2x2;

    logic        clk;
    logic        reset_b;
    logic        pool_run;
    logic [4:0]  cfg_width;
    logic [7:0]  cfg_count;
    logic        pool_busy;
    logic [11:0] pool_sram_read_address;
    logic [15:0] sram_pool_read_data;
    logic [11:0] pool_sram_write_address;
    logic [15:0] pool_sram_write_data;
    logic        pool_sram_write_enable;

    bin_maxpool2x2 #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk                     (clk),
        .reset_b                 (reset_b),
        .pool_run                (pool_run),
        .cfg_width               (cfg_width),
        .cfg_count               (cfg_count),
        .pool_busy               (pool_busy),
        .pool_sram_read_address  (pool_sram_read_address),
        .sram_pool_read_data     (sram_pool_read_data),
        .pool_sram_write_address (pool_sram_write_address),
        .pool_sram_write_data    (pool_sram_write_data),
        .pool_sram_write_enable  (pool_sram_write_enable)
    );

    logic [15:0] mem [0:4095];
    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    logic [31:0] wc [0:63];
    logic [31:0] rd_log [0:255];
    int          nw;
    int          cyc;
    int          run_cyc;
    int          fall;
    int          we_double;
    logic        prev_we;
    int          n_tests;
    int          n_fail;
    logic [15:0] exp1 [0:3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sram_pool_read_data <= mem[pool_sram_read_address];
    end

    always @(negedge clk) begin
        if (pool_sram_write_enable) begin
            if (nw < 64) begin
                wa[nw] = 32'(pool_sram_write_address);
                wd[nw] = 32'(pool_sram_write_data);
                wc[nw] = cyc - run_cyc;
            end
            nw++;
        end
        if (pool_busy && (cyc - run_cyc) < 256) rd_log[cyc - run_cyc] = 32'(pool_sram_read_address);
        if (pool_sram_write_enable && prev_we) we_double++;
        prev_we = pool_sram_write_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pool_gold(input logic [15:0] a, input logic [15:0] b, input int p);
        logic [15:0] o;
        logic [15:0] r;
        o = a | b;
        r = '0;
        for (int j = 0; j < p; j++) r[j] = o[2*j] | o[2*j+1];
        return r;
    endfunction

    task automatic start_run(input logic [4:0] w, input logic [7:0] c);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            wa[i] = 32'hDEAD; wd[i] = 32'hDEAD; wc[i] = 32'hDEAD;
        end
        nw = 0;
        run_cyc = cyc;
        cfg_width = w;
        cfg_count = c;
        pool_run = 1'b1;
        @(negedge clk);
        pool_run = 1'b0;
        cfg_width = 5'd0;
        cfg_count = 8'd0;
        check("busy_cycle1", 32'(pool_busy), 32'd1);
        check("raddr_cycle1", 32'(pool_sram_read_address), 32'd0);
    endtask

    task automatic wait_idle();
        fall = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!pool_busy) begin
                fall = cyc - run_cyc;
                break;
            end
        end
        if (fall >= 0) begin
            check("raddr_idle", 32'(pool_sram_read_address), 32'd0);
            check("waddr_idle", 32'(pool_sram_write_address), 32'd0);
        end
    endtask

    task automatic check_t1();
        check("t1_nwrites", nw, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_waddr", wa[i], i);
            check("t1_wdata", wd[i], 32'(exp1[i]));
            check("t1_wcycle", wc[i], 4 + 2*i);
        end
        check("t1_busy_fall", fall, 32'd11);
    endtask

    task automatic load_t1();
        mem[0] = 16'h0001; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h0080;
        mem[4] = 16'h0003; mem[5] = 16'h000C; mem[6] = 16'h0000; mem[7] = 16'h00C0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; nw = 0; cyc = 0; run_cyc = 0; we_double = 0; prev_we = 1'b0;
        exp1[0] = 16'h0001; exp1[1] = 16'h0008; exp1[2] = 16'h0003; exp1[3] = 16'h0008;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        reset_b = 1'b0; pool_run = 1'b0; cfg_width = 5'd0; cfg_count = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(pool_busy), 32'd0);
        check("rst_raddr", 32'(pool_sram_read_address), 32'd0);
        check("rst_waddr", 32'(pool_sram_write_address), 32'd0);
        check("rst_wdata", 32'(pool_sram_write_data), 32'd0);
        check("rst_we", 32'(pool_sram_write_enable), 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // single 8x8 image
        load_t1();
        start_run(5'd8, 8'd1);
        wait_idle();
        check_t1();
        check("t1_raddr_last", rd_log[8], 32'd7);

        // three 14x14 all-ones images
        for (int i = 0; i < 42; i++) mem[i] = 16'hFFFF;
        start_run(5'd14, 8'd3);
        wait_idle();
        check("t2_nwrites", nw, 32'd21);
        for (int i = 0; i < 21; i++) begin
            check("t2_waddr", wa[i], i);
            check("t2_wdata", wd[i], 32'h007F);
            check("t2_wcycle", wc[i], 4 + 2*i);
        end
        for (int n = 0; n < 42; n++) check("t2_raddr", rd_log[n+1], n);
        check("t2_busy_fall", fall, 32'd45);

        // W=9, two images, random data: rows 8 and 17 skipped
        for (int i = 0; i < 18; i++) mem[i] = 16'($urandom);
        start_run(5'd9, 8'd2);
        wait_idle();
        check("t3_nwrites", nw, 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("t3_waddr", wa[k], k);
            check("t3_wdata", wd[k],
                  32'(pool_gold(mem[(k/4)*9 + 2*(k%4)], mem[(k/4)*9 + 2*(k%4) + 1], 4)));
            check("t3_wcycle", wc[k], 4 + 2*k);
        end
        for (int n = 0; n < 16; n++) check("t3_raddr", rd_log[n+1], (n < 8) ? n : n + 1);
        check("t3_busy_fall", fall, 32'd19);

        // degenerate runs
        start_run(5'd1, 8'd3);
        wait_idle();
        check("deg_w1_fall", fall, 32'd2);
        check("deg_w1_nwrites", nw, 32'd0);
        start_run(5'd8, 8'd0);
        wait_idle();
        check("deg_c0_fall", fall, 32'd2);
        check("deg_c0_nwrites", nw, 32'd0);

        // width 20 clamps to 16
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        start_run(5'd20, 8'd1);
        wait_idle();
        check("w20_nwrites", nw, 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("w20_wdata", wd[k], 32'(pool_gold(mem[2*k], mem[2*k+1], 8)));
            check("w20_wcycle", wc[k], 4 + 2*k);
        end
        check("w20_busy_fall", fall, 32'd19);

        // reset during the third write of a W=16 run
        start_run(5'd16, 8'd1);
        repeat (7) @(negedge clk);
        check("rst3_we_before", 32'(pool_sram_write_enable), 32'd1);
        check("rst3_waddr_before", 32'(pool_sram_write_address), 32'd2);
        #2 reset_b = 1'b0;
        #1;
        check("rst3_busy", 32'(pool_busy), 32'd0);
        check("rst3_raddr", 32'(pool_sram_read_address), 32'd0);
        check("rst3_waddr", 32'(pool_sram_write_address), 32'd0);
        check("rst3_wdata", 32'(pool_sram_write_data), 32'd0);
        check("rst3_we", 32'(pool_sram_write_enable), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        load_t1();
        start_run(5'd8, 8'd1);
        wait_idle();
        check_t1();

        // pool_run held high: no restart while busy, re-accepted in first idle cycle
        mem[0] = 16'h0002; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h0008;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            wa[i] = 32'hDEAD; wd[i] = 32'hDEAD; wc[i] = 32'hDEAD;
        end
        nw = 0;
        run_cyc = cyc;
        cfg_width = 5'd4;
        cfg_count = 8'd1;
        pool_run = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            @(negedge clk);
            check("hold_busy", 32'(pool_busy), ((r >= 1 && r <= 6) || (r >= 8 && r <= 13)) ? 32'd1 : 32'd0);
            if (r == 8) begin
                pool_run = 1'b0;
                cfg_width = 5'd0;
                cfg_count = 8'd0;
            end
        end
        check("hold_nwrites", nw, 32'd4);
        check("hold_wa2", wa[2], 32'd0);
        check("hold_wa3", wa[3], 32'd1);
        check("hold_wd0", wd[0], 32'h1);
        check("hold_wd1", wd[1], 32'h2);
        check("hold_wd3", wd[3], 32'h2);
        check("hold_wc1", wc[1], 32'd6);
        check("hold_wc2", wc[2], 32'd11);
        check("hold_wc3", wc[3], 32'd13);

        check("no_back_to_back_we", we_double, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
